alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
Parametrised WIDTH-bit multi-cycle ALU. It is the successor to the per-bit ALU slice used for the midterm datapath.
- Single-cycle ops (AND/OR/ADD/SUB/SLT) return a registered result with fixed latency 1.
- MULTU runs a WIDTH-cycle shift-add sequence into internal HI/LO registers; MFHI/MFLO read them back.
- Valid/ready handshake on both sides; sits between the ID/EX operand latch and the EX result latch.

Parameters:
WIDTH, 32, operand/result width (>=4)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
In_valid  input  1  operation request
In_ready  output  1  block can accept; combinational from state and Out_ready
A  input  WIDTH  operand A
B  input  WIDTH  operand B
Signal  input  6  funct code: AND 36, OR 37, ADD 32, SUB 34, SLT 42, MULTU 25, MFHI 16, MFLO 18
Out_valid  output  1  Result/flags valid
Out_ready  input  1  consumer takes result
Result  output  WIDTH  registered result
Zero  output  1  Result == 0 (registered with Result)
Overflow  output  1  signed overflow, ADD/SUB only; 0 for all other ops

Behaviour:
- Reset (reset=0, async): state=IDLE; Result=0, Zero=0, Overflow=0, Out_valid=0, HI=LO=0, counter=0. A reset mid-MULTU aborts the operation and produces no output.
- States and transitions:
  - IDLE: In_ready=1.
  - BUSY: MULTU iterating; In_ready=0.
  - OUT: Out_valid=1; In_ready=Out_ready.
- Accept = In_valid & In_ready at a rising edge. In_ready=0 means inputs are ignored.
- Single-cycle op accepted at edge k: Result, flags and Out_valid are registered at edge k; state goes to OUT; visible from edge k.
- MULTU accepted at edge k:
  - Load multiplicand, multiplier and product=0; go to BUSY.
  - Each BUSY edge conditionally adds the shifted multiplicand; counter increments.
  - The edge on which counter reaches WIDTH writes {HI,LO}=2*WIDTH-bit unsigned product and goes to OUT with Result=LO.
  - Out_valid therefore rises at edge k+WIDTH.
- OUT hold: while Out_ready=0, Result, Zero, Overflow and Out_valid stay stable.
- OUT drain:
  - Out_ready=1 with no new accept → IDLE, Out_valid=0.
  - Out_ready=1 with a simultaneous accept → the new op is taken back-to-back (single-cycle op stays in OUT; MULTU goes to BUSY with Out_valid=0).
- Arithmetic:
  - ADD/SUB wrap modulo 2^WIDTH.
  - SUB = A + ~B + 1.
  - Overflow = operand signs equal (B inverted for SUB) and result sign differs.
  - SLT: Result = {0..0, (sum_msb XOR overflow)}, i.e. signed A<B correct even on overflow; Overflow flag reported 0.
  - AND/OR are bitwise.
- MFHI/MFLO: Result=HI/LO, latency 1. HI/LO change only on MULTU completion.
- Unknown Signal: accepted, Result=0, Zero=1, Overflow=0, latency 1.

Optional Feature:
ALU_DIVU_EN
- Defined:
  - DIVU (funct 27) is supported as a WIDTH-cycle restoring division using BUSY, with the same timing as MULTU.
  - LO=quotient, HI=remainder; Result=LO.
  - Divide-by-zero: LO=all ones, HI=A; timing unchanged.
- Undefined: funct 27 is handled as an unknown Signal.

Decomposition:
- Shared package alu_pkg holds:
  - funct localparams (FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_MULTU, FN_MFHI, FN_MFLO, FN_DIVU);
  - state encoding IDLE/BUSY/OUT as a typedef'd enum.
- Sub-module alu_comb: purely combinational WIDTH-bit AND/OR/ADD/SUB/SLT with Result/Overflow. alu_mc owns the handshake, FSM, HI/LO and the iterative datapath.

Test Plan:
- ADD, WIDTH=32: A=0x7FFFFFFF, B=1, Out_ready=1 → Out_valid 1 cycle after accept, Result=0x80000000, Overflow=1, Zero=0.
- SUB then SLT: SUB A=5, B=5 → Result=0, Zero=1. SLT A=0x80000000, B=1 → Result=1, Overflow=0.
- MULTU A=0xFFFFFFFF, B=2 → In_ready=0 during BUSY; Out_valid at accept+32; Result=LO=0xFFFFFFFE. Follow with MFHI → Result=1.
- Backpressure: hold Out_ready=0 for 5 cycles after an AND → Result stable, In_ready=0. Then raise Out_ready together with In_valid (OR) → back-to-back accept, new Result next edge.
- Reset pulse at BUSY cycle 10 of MULTU → Out_valid=0, Result=0, MFLO afterwards returns 0.
- With ALU_DIVU_EN: DIVU A=100, B=7 → LO=14, HI=2. DIVU B=0, A=9 → LO=0xFFFFFFFF, HI=9. Without the macro: funct 27 → Result=0, Zero=1.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared funct codes and FSM state encoding for the multi-cycle ALU
// Purpose: funct localparams and the IDLE/BUSY/OUT state type used by alu_mc and alu_comb.
// Ports: none (package).
package alu_pkg;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_comb.sv
// rtl/alu_comb.sv - combinational AND/OR/ADD/SUB/SLT core
// Purpose: single-cycle arithmetic/logic for alu_mc; result is 0 for any other funct.
// Ports:
//   op       funct code
//   a, b     WIDTH-bit operands
//   result   WIDTH-bit result
//   overflow signed overflow, ADD/SUB only
module alu_comb #(
  parameter int WIDTH = 32
) (
  input  logic [5:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);
  import alu_pkg::*;

  logic             sub;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic             ovf;

  always_comb begin
    // SLT shares the subtractor: A - B, then sign corrected by overflow.
    sub      = (op == FN_SUB) || (op == FN_SLT);
    b_eff    = sub ? ~b : b;
    sum      = a + b_eff + {{(WIDTH-1){1'b0}}, sub};
    ovf      = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    result   = '0;
    overflow = 1'b0;
    case (op)
      FN_AND: result = a & b;
      FN_OR:  result = a | b;
      FN_ADD, FN_SUB: begin
        result   = sum;
        overflow = ovf;
      end
      FN_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with valid/ready handshake and HI/LO registers
// Purpose: single-cycle ops (latency 1), MULTU as WIDTH-cycle shift-add, MFHI/MFLO.
// Optional: define ALU_DIVU_EN to add DIVU (funct 27) as WIDTH-cycle restoring division.
// Ports:
//   clk, reset            clock (rising edge), async active-low reset
//   In_valid, In_ready    request handshake (In_ready combinational)
//   A, B, Signal          operands and funct code
//   Out_valid, Out_ready  result handshake
//   Result, Zero, Overflow registered result and flags
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             In_valid,
  output logic             In_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       Signal,
  output logic             Out_valid,
  input  logic             Out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Overflow
);
  import alu_pkg::*;

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_t             state;
  logic [WIDTH-1:0]   hi, lo;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;

  logic [2*WIDTH-1:0] acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]   mplier_nxt, hi_fin, lo_fin;
  logic [WIDTH-1:0]   comb_res, sc_res;
  logic               comb_ovf, accept, iter_op;

`ifdef ALU_DIVU_EN
  logic               is_div;
  logic [WIDTH:0]     rem_sh, trial;
`endif

  alu_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (Signal),
    .a        (A),
    .b        (B),
    .result   (comb_res),
    .overflow (comb_ovf)
  );

  assign In_ready = (state == IDLE) || ((state == OUT) && Out_ready);
  assign accept   = In_valid && In_ready;

  always_comb begin
    iter_op = (Signal == FN_MULTU);
`ifdef ALU_DIVU_EN
    if (Signal == FN_DIVU) iter_op = 1'b1;
`endif
    case (Signal)
      FN_MFHI: sc_res = hi;
      FN_MFLO: sc_res = lo;
      default: sc_res = comb_res;
    endcase
  end

  // One iteration of the sequential datapath. Multiply: acc accumulates the
  // left-shifting multiplicand for each set multiplier bit (LSB first).
  always_comb begin
    mcand_nxt  = mcand << 1;
    mplier_nxt = mplier >> 1;
    acc_nxt    = mplier[0] ? acc + mcand : acc;
    hi_fin     = acc_nxt[2*WIDTH-1:WIDTH];
    lo_fin     = acc_nxt[WIDTH-1:0];
`ifdef ALU_DIVU_EN
    // Divide: acc holds the partial remainder, mplier shifts dividend bits out
    // and quotient bits in, mcand holds the divisor. A zero divisor never
    // borrows, so the quotient saturates to all ones and the remainder ends as A.
    rem_sh = {acc[WIDTH-1:0], mplier[WIDTH-1]};
    trial  = rem_sh - {1'b0, mcand[WIDTH-1:0]};
    if (is_div) begin
      mcand_nxt = mcand;
      if (!trial[WIDTH]) begin
        acc_nxt    = {{(WIDTH-1){1'b0}}, trial};
        mplier_nxt = {mplier[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt    = {{(WIDTH-1){1'b0}}, rem_sh};
        mplier_nxt = {mplier[WIDTH-2:0], 1'b0};
      end
      hi_fin = acc_nxt[WIDTH-1:0];
      lo_fin = mplier_nxt;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      Result    <= '0;
      Zero      <= 1'b0;
      Overflow  <= 1'b0;
      Out_valid <= 1'b0;
      hi        <= '0;
      lo        <= '0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
`ifdef ALU_DIVU_EN
      is_div    <= 1'b0;
`endif
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            hi        <= hi_fin;
            lo        <= lo_fin;
            Result    <= lo_fin;
            Zero      <= (lo_fin == '0);
            Overflow  <= 1'b0;
            Out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        default: begin
          if (accept) begin
            if (iter_op) begin
              acc       <= '0;
              mcand     <= {{WIDTH{1'b0}}, A};
              mplier    <= B;
`ifdef ALU_DIVU_EN
              is_div    <= (Signal == FN_DIVU);
              if (Signal == FN_DIVU) begin
                mcand  <= {{WIDTH{1'b0}}, B};
                mplier <= A;
              end
`endif
              cnt       <= '0;
              Out_valid <= 1'b0;
              state     <= BUSY;
            end else begin
              Result    <= sc_res;
              Zero      <= (sc_res == '0);
              Overflow  <= comb_ovf;
              Out_valid <= 1'b1;
              state     <= OUT;
            end
          end else if ((state == OUT) && Out_ready) begin
            Out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// tb/tb_alu_mc.sv - self-checking bench for alu_mc (WIDTH=32), optional ALU_DIVU_EN
module tb_alu_mc;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          In_valid, In_ready, Out_valid, Out_ready;
  logic [W-1:0]  A, B, Result;
  logic [5:0]    Signal;
  logic          Zero, Overflow;

  int            tests_run = 0;
  int            tests_failed = 0;
  logic [W-1:0]  m_hi = '0, m_lo = '0;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .A         (A),
    .B         (B),
    .Signal    (Signal),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Result    (Result),
    .Zero      (Zero),
    .Overflow  (Overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Reference model: arithmetic straight from the op definitions.
  task automatic model(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] r, output logic z, output logic ov, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; ov = 1'b0; lat = 0;
    case (fn)
      6'd36: r = a & b;
      6'd37: r = a | b;
      6'd32: begin s = sa + sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd34: begin s = sa - sb; r = s[31:0]; ov = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
      6'd42: r = (sa < sb) ? 32'd1 : 32'd0;
      6'd25: begin p = {32'b0, a} * {32'b0, b}; m_hi = p[63:32]; m_lo = p[31:0]; r = m_lo; lat = W; end
      6'd16: r = m_hi;
      6'd18: r = m_lo;
      default: r = '0;
    endcase
`ifdef ALU_DIVU_EN
    if (fn == 6'd27) begin
      if (b == 0) begin m_lo = '1; m_hi = a; end
      else begin m_lo = a / b; m_hi = a % b; end
      r = m_lo; lat = W;
    end
`endif
    z = (r == '0);
  endtask

  // Issue one op from IDLE, wait for the result, then drain it.
  task automatic run_op(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic [W-1:0] r, output logic z, output logic ov,
                        output int rdy_hi);
    @(negedge clk);
    Signal = fn; A = a; B = b; In_valid = 1'b1; Out_ready = 1'b0;
    @(posedge clk); #1;
    In_valid = 1'b0; A = $urandom; B = $urandom;
    lat = 0; rdy_hi = 0;
    while (!Out_valid && lat < 200) begin
      if (In_ready) rdy_hi++;
      @(posedge clk); #1;
      lat++;
    end
    r = Result; z = Zero; ov = Overflow;
    @(negedge clk); Out_ready = 1'b1;
    @(posedge clk); #1; Out_ready = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; In_valid = 1'b0; Out_ready = 1'b0; A = '0; B = '0; Signal = '0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++; if (Out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b expected 0", Out_valid); end
    tests_run++; if (Result !== '0) begin tests_failed++; $display("FAIL reset_result: got %h expected 0", Result); end
    tests_run++; if (Zero !== 1'b0) begin tests_failed++; $display("FAIL reset_zero: got %b expected 0", Zero); end
    tests_run++; if (Overflow !== 1'b0) begin tests_failed++; $display("FAIL reset_overflow: got %b expected 0", Overflow); end
    tests_run++; if (In_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_in_ready: got %b expected 1", In_ready); end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_add_overflow;
    int lat, rh; logic [W-1:0] r; logic z, ov;
    run_op(6'd32, 32'h7FFFFFFF, 32'h1, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'h80000000) begin tests_failed++; $display("FAIL add_result: got %h expected 80000000", r); end
    tests_run++; if (ov !== 1'b1) begin tests_failed++; $display("FAIL add_overflow: got %b expected 1", ov); end
    tests_run++; if (z !== 1'b0) begin tests_failed++; $display("FAIL add_zero: got %b expected 0", z); end
    tests_run++; if (lat !== 0) begin tests_failed++; $display("FAIL add_latency: got %0d expected 0", lat); end
  endtask

  task automatic test_sub_slt;
    int lat, rh; logic [W-1:0] r; logic z, ov;
    run_op(6'd34, 32'd5, 32'd5, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd0 || z !== 1'b1) begin tests_failed++; $display("FAIL sub_equal: got %h/%b expected 0/1", r, z); end
    run_op(6'd42, 32'h80000000, 32'd1, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd1 || ov !== 1'b0) begin tests_failed++; $display("FAIL slt_min: got %h/%b expected 1/0", r, ov); end
    run_op(6'd42, 32'h7FFFFFFF, 32'hFFFFFFFF, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd0 || z !== 1'b1) begin tests_failed++; $display("FAIL slt_ovf: got %h/%b expected 0/1", r, z); end
  endtask

  task automatic test_multu;
    int lat, rh, el; logic [W-1:0] r, er; logic z, ov, ez, eov;
    model(6'd25, 32'hFFFFFFFF, 32'd2, er, ez, eov, el);
    run_op(6'd25, 32'hFFFFFFFF, 32'd2, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL multu_lo: got %h expected fffffffe", r); end
    tests_run++; if (lat !== W) begin tests_failed++; $display("FAIL multu_latency: got %0d expected %0d", lat, W); end
    tests_run++; if (rh !== 0) begin tests_failed++; $display("FAIL multu_in_ready_busy: got %0d ready cycles expected 0", rh); end
    run_op(6'd16, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd1 || lat !== 0) begin tests_failed++; $display("FAIL mfhi: got %h lat %0d expected 1 lat 0", r, lat); end
    run_op(6'd18, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'hFFFFFFFE) begin tests_failed++; $display("FAIL mflo: got %h expected fffffffe", r); end
  endtask

  task automatic test_random;
    logic [5:0]   ops [11] = '{6'd36, 6'd37, 6'd32, 6'd34, 6'd42, 6'd25, 6'd16, 6'd18, 6'd27, 6'd0, 6'd63};
    logic [W-1:0] edges [6] = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h7};
    logic [5:0] fn; logic [W-1:0] a, b, r, er; logic z, ov, ez, eov; int lat, el, rh;
    for (int i = 0; i < 30; i++) begin
      fn = ops[$urandom_range(0, 10)];
      a = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 5)] : $urandom;
      model(fn, a, b, er, ez, eov, el);
      run_op(fn, a, b, lat, r, z, ov, rh);
      tests_run++; if (r !== er) begin tests_failed++; $display("FAIL rand_result fn=%0d a=%h b=%h: got %h expected %h", fn, a, b, r, er); end
      tests_run++; if (z !== ez) begin tests_failed++; $display("FAIL rand_zero fn=%0d: got %b expected %b", fn, z, ez); end
      tests_run++; if (ov !== eov) begin tests_failed++; $display("FAIL rand_overflow fn=%0d a=%h b=%h: got %b expected %b", fn, a, b, ov, eov); end
      tests_run++; if (lat !== el) begin tests_failed++; $display("FAIL rand_latency fn=%0d: got %0d expected %0d", fn, lat, el); end
      tests_run++; if (rh !== 0) begin tests_failed++; $display("FAIL rand_in_ready_busy fn=%0d: got %0d expected 0", fn, rh); end
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a, b, er, r; logic ez, eov; int el, lat;
    a = $urandom; b = $urandom;
    @(negedge clk); Signal = 6'd36; A = a; B = b; In_valid = 1'b1; Out_ready = 1'b0;
    @(posedge clk); #1; In_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      tests_run++; if (Result !== (a & b) || Out_valid !== 1'b1) begin tests_failed++; $display("FAIL hold_stable: got %h/%b expected %h/1", Result, Out_valid, a & b); end
      tests_run++; if (In_ready !== 1'b0) begin tests_failed++; $display("FAIL hold_in_ready: got %b expected 0", In_ready); end
    end
    a = $urandom; b = $urandom;
    @(negedge clk); Out_ready = 1'b1; In_valid = 1'b1; Signal = 6'd37; A = a; B = b;
    #1;
    tests_run++; if (In_ready !== 1'b1) begin tests_failed++; $display("FAIL b2b_in_ready: got %b expected 1", In_ready); end
    @(posedge clk); #1; In_valid = 1'b0; Out_ready = 1'b0;
    tests_run++; if (Result !== (a | b) || Out_valid !== 1'b1) begin tests_failed++; $display("FAIL b2b_or: got %h/%b expected %h/1", Result, Out_valid, a | b); end
    // Drain the OR while accepting a MULTU: output must drop during BUSY.
    a = $urandom; b = $urandom;
    model(6'd25, a, b, er, ez, eov, el);
    @(negedge clk); Out_ready = 1'b1; In_valid = 1'b1; Signal = 6'd25; A = a; B = b;
    @(posedge clk); #1; In_valid = 1'b0; Out_ready = 1'b0;
    tests_run++; if (Out_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_multu_valid: got %b expected 0", Out_valid); end
    lat = 0;
    while (!Out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    r = Result;
    tests_run++; if (r !== er || lat !== el) begin tests_failed++; $display("FAIL b2b_multu: got %h lat %0d expected %h lat %0d", r, lat, er, el); end
    @(negedge clk); Out_ready = 1'b1;
    @(posedge clk); #1; Out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_multu;
    int lat, rh, seen; logic [W-1:0] r; logic z, ov;
    @(negedge clk); Signal = 6'd25; A = $urandom | 32'h1; B = $urandom | 32'h1; In_valid = 1'b1; Out_ready = 1'b1;
    @(posedge clk); #1; In_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); reset = 1'b0; #1;
    tests_run++; if (Out_valid !== 1'b0 || Result !== '0) begin tests_failed++; $display("FAIL midreset_out: got %b/%h expected 0/0", Out_valid, Result); end
    tests_run++; if (In_ready !== 1'b1) begin tests_failed++; $display("FAIL midreset_in_ready: got %b expected 1", In_ready); end
    @(negedge clk); reset = 1'b1; Out_ready = 1'b0;
    m_hi = '0; m_lo = '0;
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (Out_valid) seen++; end
    tests_run++; if (seen !== 0) begin tests_failed++; $display("FAIL midreset_no_output: got %0d valid cycles expected 0", seen); end
    run_op(6'd18, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== '0 || z !== 1'b1) begin tests_failed++; $display("FAIL midreset_mflo: got %h/%b expected 0/1", r, z); end
    run_op(6'd16, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== '0) begin tests_failed++; $display("FAIL midreset_mfhi: got %h expected 0", r); end
  endtask

  task automatic test_divu;
    int lat, rh, el; logic [W-1:0] r, er; logic z, ov, ez, eov;
`ifdef ALU_DIVU_EN
    model(6'd27, 32'd100, 32'd7, er, ez, eov, el);
    run_op(6'd27, 32'd100, 32'd7, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd14 || lat !== W) begin tests_failed++; $display("FAIL divu_lo: got %h lat %0d expected 0000000e lat %0d", r, lat, W); end
    run_op(6'd16, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd2) begin tests_failed++; $display("FAIL divu_hi: got %h expected 2", r); end
    model(6'd27, 32'd9, 32'd0, er, ez, eov, el);
    run_op(6'd27, 32'd9, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'hFFFFFFFF || lat !== W) begin tests_failed++; $display("FAIL divu_zero_lo: got %h lat %0d expected ffffffff lat %0d", r, lat, W); end
    run_op(6'd16, 32'd0, 32'd0, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd9) begin tests_failed++; $display("FAIL divu_zero_hi: got %h expected 9", r); end
`else
    model(6'd27, 32'd100, 32'd7, er, ez, eov, el);
    run_op(6'd27, 32'd100, 32'd7, lat, r, z, ov, rh);
    tests_run++; if (r !== 32'd0 || z !== 1'b1 || ov !== 1'b0) begin tests_failed++; $display("FAIL funct27_unknown: got %h/%b/%b expected 0/1/0", r, z, ov); end
    tests_run++; if (lat !== 0) begin tests_failed++; $display("FAIL funct27_latency: got %0d expected 0", lat); end
`endif
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_slt();
    test_multu();
    test_back_to_back();
    test_reset_mid_multu();
    test_divu();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
